aeb_scan_scheduler: RTL
=======================

AEB_SCAN_SCHEDULER -- requirements
Module: aeb_scan_scheduler

Interface
REQ-001 Parameter FRAME_WIDTH, 320, frame width in pixels.
REQ-002 Parameter FRAME_HEIGHT, 240, frame height in pixels.
REQ-003 Parameter ADDR_W, 24, frame-buffer pixel address width.
REQ-004 Parameter DATA_W, 8, pixel width.
REQ-005 Port clk  in  1  single clock; all logic rising-edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port start  in  1  request one scan pass.
REQ-008 Ports crop_x0, crop_y0, crop_w, crop_h  in  16 each  crop window; sampled only when start is accepted.
REQ-009 Port busy  out  1  high in RUN and DRAIN.
REQ-010 Port done  out  1  one-cycle pulse at pass end.
REQ-011 Port cfg_err  out  1  one-cycle pulse on rejected config.
REQ-012 Port mem_rd_en  out  1  frame-buffer read strobe.
REQ-013 Port mem_rd_addr  out  ADDR_W  frame-buffer read address.
REQ-014 Port mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en.
REQ-015 Ports pix_valid out 1, pix_ready in 1, pix_data out DATA_W  downstream valid/ready stream.
REQ-016 Ports pix_x, pix_y  out  16  crop-relative coordinates of pix_data.
REQ-017 Ports pix_sol, pix_eof  out  1  first pixel of crop row; last pixel of pass.

Function
REQ-018 States IDLE, RUN, DRAIN, DONE; IDLE after reset.
REQ-019 IDLE: start=1 with valid config -> RUN next cycle; config latched.
REQ-020 Config invalid if crop_w=0, crop_h=0, crop_x0+crop_w>FRAME_WIDTH or crop_y0+crop_h>FRAME_HEIGHT (17-bit sums, no overflow); then cfg_err=1 next cycle, stay IDLE, no reads.
REQ-021 start ignored outside IDLE.
REQ-022 Scan raster order: x 0..crop_w-1 inner, y 0..crop_h-1 outer.
REQ-023 mem_rd_addr = (crop_y0+y)*FRAME_WIDTH + crop_x0 + x; computed incrementally (+1 within row, row_base+FRAME_WIDTH at row change); no runtime multiplier in RUN.
REQ-024 First mem_rd_en in the first RUN cycle (cycle after start accepted).
REQ-025 Output buffer: 2-entry FIFO carrying data, x, y, sol, eof.
REQ-026 Read issued in a cycle iff RUN and (occupancy + in-flight - pop_this_cycle) < 2; pop = pix_valid & pix_ready.
REQ-027 Returned data written to FIFO at end of its valid cycle; pix_valid high from the following cycle.
REQ-028 With pix_ready held 1, sustained throughput one pixel per cycle after fill.
REQ-029 pix_valid & !pix_ready: all pix_* outputs held stable.
REQ-030 Simultaneous push and pop: occupancy unchanged, order preserved.
REQ-031 Last address issued -> DRAIN; DRAIN -> DONE on the cycle the eof pixel is popped.
REQ-032 DONE lasts exactly one cycle: done=1, busy=0, then IDLE.
REQ-033 pix_sol=1 iff x=0; pix_eof=1 iff x=crop_w-1 and y=crop_h-1.
REQ-034 Single-pixel crop (w=h=1): one read, pix_sol=pix_eof=1.

Reset
REQ-035 reset=1 at any edge: state IDLE, FIFO and in-flight flag cleared, busy, done, cfg_err, mem_rd_en, pix_valid, pix_sol, pix_eof = 0; mem_rd_addr, pix_data, pix_x, pix_y = 0.
REQ-036 Reset overrides start in the same cycle; memory data returning after reset is discarded.

Verification
REQ-037 FRAME 8x4, crop (0,0,8,4), pix_ready=1 -> addresses 0..31 on 32 consecutive cycles, 32 pixels in order, one done pulse, busy low afterwards.
REQ-038 FRAME 8x4, crop (2,1,3,2) -> addresses 10,11,12,18,19,20; pix_x 0,1,2,0,1,2; pix_sol on addr 10 and 18; pix_eof on addr 20 only.
REQ-039 Random pix_ready (50%) over full 8x4 frame -> 32 pixels, none lost or duplicated, outputs stable while stalled, FIFO occupancy + in-flight never > 2.
REQ-040 crop (6,0,3,4) on width 8 -> cfg_err pulse one cycle after start, no mem_rd_en, busy stays 0.
REQ-041 reset after 5 pixels popped -> all outputs at reset values next cycle; new start with crop (0,0,2,2) yields addresses 0,1,8,9 and clean done.
REQ-042 start pulsed during RUN and in DONE cycle -> ignored; exactly one pass and one done pulse.

Source files
------------

// File: rtl/aeb_scan_scheduler.sv
// Crop-window raster scan scheduler: walks a crop rectangle of a frame buffer,
// issues pixel reads and streams the returned pixels through a 2-entry output FIFO.
module aeb_scan_scheduler #(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240,
   parameter int ADDR_W       = 24,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       crop_x0,
   input  logic [15:0]       crop_y0,
   input  logic [15:0]       crop_w,
   input  logic [15:0]       crop_h,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic [15:0]       pix_x,
   output logic [15:0]       pix_y,
   output logic              pix_sol,
   output logic              pix_eof
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // FIFO entry layout: {data, x, y, sol, eof}
   localparam int E_W = DATA_W + 34;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [15:0]       r_w;
   logic [15:0]       r_h;
   logic [15:0]       r_x;
   logic [15:0]       r_y;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] w_start_base;
   logic              r_inflight;
   logic [15:0]       r_fl_x;
   logic [15:0]       r_fl_y;
   logic              r_fl_sol;
   logic              r_fl_eof;
   logic [1:0]        r_cnt;
   logic [E_W-1:0]    r_head;
   logic [E_W-1:0]    r_tail;
   logic [E_W-1:0]    w_new;
   logic              r_busy;
   logic              r_done;
   logic              r_cfg_err;

   logic [16:0]       w_xend;
   logic [16:0]       w_yend;
   logic              w_cfg_ok;
   logic              w_start_ok;
   logic              w_start_bad;
   logic              w_pop;
   logic [2:0]        w_level;
   logic              w_space;
   logic              w_rd_en;
   logic              w_row_end;
   logic              w_last;

   // 17-bit sums so a window running past 0xFFFF is still rejected
   assign w_xend      = {1'b0, crop_x0} + {1'b0, crop_w};
   assign w_yend      = {1'b0, crop_y0} + {1'b0, crop_h};
   assign w_cfg_ok    = (crop_w != 16'd0) && (crop_h != 16'd0) &&
                        (w_xend <= 17'(FRAME_WIDTH)) && (w_yend <= 17'(FRAME_HEIGHT));
   assign w_start_ok  = start && (r_state == S_IDLE) && w_cfg_ok;
   assign w_start_bad = start && (r_state == S_IDLE) && !w_cfg_ok;
   assign w_start_base = ADDR_W'(crop_y0) * ADDR_W'(FRAME_WIDTH) + ADDR_W'(crop_x0);

   assign w_pop     = (r_cnt != 2'd0) && pix_ready;
   assign w_level   = {1'b0, r_cnt} + {2'b00, r_inflight};
   assign w_space   = (w_level - {2'b00, w_pop}) < 3'd2;
   assign w_rd_en   = (r_state == S_RUN) && w_space;
   assign w_row_end = (r_x == (r_w - 16'd1));
   assign w_last    = w_row_end && (r_y == (r_h - 16'd1));

   assign w_new = {mem_rd_data, r_fl_x, r_fl_y, r_fl_sol, r_fl_eof};

   // Pass sequencing
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_nxt = S_RUN;
            else            w_state_nxt = S_IDLE;
         end
         S_RUN: begin
            if (w_rd_en && w_last) w_state_nxt = S_DRAIN;
            else                   w_state_nxt = S_RUN;
         end
         S_DRAIN: begin
            if (w_pop && r_head[0]) w_state_nxt = S_DONE;
            else                    w_state_nxt = S_DRAIN;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control state, status pulses, scan counters and address generation
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_inflight <= 1'b0;
         r_w        <= 16'd0;
         r_h        <= 16'd0;
         r_x        <= 16'd0;
         r_y        <= 16'd0;
         r_addr     <= '0;
         r_row_base <= '0;
         r_fl_x     <= 16'd0;
         r_fl_y     <= 16'd0;
         r_fl_sol   <= 1'b0;
         r_fl_eof   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
         r_done     <= (w_state_nxt == S_DONE);
         r_cfg_err  <= w_start_bad;
         r_inflight <= w_rd_en;
         if (w_rd_en) begin
            r_fl_x   <= r_x;
            r_fl_y   <= r_y;
            r_fl_sol <= (r_x == 16'd0);
            r_fl_eof <= w_last;
         end
         if (w_start_ok) begin
            r_w        <= crop_w;
            r_h        <= crop_h;
            r_x        <= 16'd0;
            r_y        <= 16'd0;
            r_row_base <= w_start_base;
            r_addr     <= w_start_base;
         end else if (w_rd_en) begin
            // Stepping past the last pixel is harmless: no further read is issued.
            if (w_row_end) begin
               r_x        <= 16'd0;
               r_y        <= r_y + 16'd1;
               r_row_base <= r_row_base + ADDR_W'(FRAME_WIDTH);
               r_addr     <= r_row_base + ADDR_W'(FRAME_WIDTH);
            end else begin
               r_x    <= r_x + 16'd1;
               r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Two-entry output FIFO; r_head is presented directly on the pix_* outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case ({r_inflight, w_pop})
            2'b11: begin
               if (r_cnt == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= w_new;
               end else begin
                  r_head <= w_new;
               end
            end
            2'b10: begin
               if (r_cnt == 2'd0) r_head <= w_new;
               else               r_tail <= w_new;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               if (r_cnt == 2'd2) r_head <= r_tail;
               r_cnt <= r_cnt - 2'd1;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign cfg_err     = r_cfg_err;
   assign mem_rd_en   = w_rd_en;
   assign mem_rd_addr = r_addr;
   assign pix_valid   = (r_cnt != 2'd0);
   assign pix_data    = r_head[E_W-1 -: DATA_W];
   assign pix_x       = r_head[33:18];
   assign pix_y       = r_head[17:2];
   assign pix_sol     = r_head[1];
   assign pix_eof     = r_head[0];

endmodule
